// File: rtl/prn_code_gen_mc.sv
// rtl/prn_code_gen_mc.sv - multi-channel coupled-register PRN code generator
// N_CH channels share one chip-rate divider and chip counter, so they stay chip/epoch aligned.
module prn_code_gen_mc #(
    parameter int N_CH = 4,
    parameter int LEN = 55,
    parameter int CODE_LEN = 10230,
    parameter int DIV_W = 8,
    parameter logic [LEN-1:0] T0_MASK = LEN'(55'h0000_0000_0FC1),
    parameter logic [LEN-1:0] T1_MASK = LEN'(55'h0000_0000_0FC1),
    parameter logic [LEN-1:0] CP_MASK = LEN'(55'h0000_0000_F101),
    parameter logic [LEN-1:0] SG_MASK = LEN'(55'h0000_0000_0FC1),
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int IDX_W = $clog2(CODE_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             load_data,
    input  logic [CH_W-1:0]  load_ch,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic [N_CH-1:0]  chip_out,
    output logic             chip_valid,
    output logic             epoch,
    output logic [IDX_W-1:0] chip_idx,
    output logic             busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    logic [0:0]                state_q, state_d;
    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]          chip_cnt_q, chip_cnt_d;
    logic [N_CH-1:0][LEN-1:0]  seed_r0_q, seed_r0_d, seed_r1_q, seed_r1_d;
    logic [N_CH-1:0][4:0]      seed_rf_q, seed_rf_d;
    logic [N_CH-1:0][LEN-1:0]  r0_q, r0_d, r1_q, r1_d;
    logic [N_CH-1:0][4:0]      rf_q, rf_d;
    logic [N_CH-1:0]           chip_out_q, chip_out_d;
    logic                      chip_valid_q, chip_valid_d;
    logic                      epoch_q, epoch_d;
    logic [IDX_W-1:0]          chip_idx_q, chip_idx_d;
    logic                      tick;

    // XOR of all pairwise ANDs of the selected bits == bit 1 of their popcount
    function automatic logic sigma2(input logic [LEN-1:0] r0);
        logic [1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LEN; i++) begin
            cnt = cnt + {1'b0, r0[i] & SG_MASK[i]};
        end
        return cnt[1];
    endfunction

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        chip_cnt_d   = chip_cnt_q;
        seed_r0_d    = seed_r0_q;
        seed_r1_d    = seed_r1_q;
        seed_rf_d    = seed_rf_q;
        r0_d         = r0_q;
        r1_d         = r1_q;
        rf_d         = rf_q;
        chip_out_d   = chip_out_q;
        chip_idx_d   = chip_idx_q;
        chip_valid_d = 1'b0;
        epoch_d      = 1'b0;
        tick         = (div_cnt_q == div);

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_RUN;
                    r0_d       = seed_r0_q;
                    r1_d       = seed_r1_q;
                    rf_d       = seed_rf_q;
                    div_cnt_d  = '0;
                    chip_cnt_d = '0;
                end else if (load_en) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (CH_W'(k) == load_ch) begin
                            seed_rf_d[k] = {seed_rf_q[k][3:0], load_data};
                            seed_r1_d[k] = {seed_r1_q[k][LEN-2:0], seed_rf_q[k][4]};
                            seed_r0_d[k] = {seed_r0_q[k][LEN-2:0], seed_r1_q[k][LEN-1]};
                        end
                    end
                end
            end
            default: begin
                if (!run) begin
                    state_d    = S_IDLE;
                    chip_out_d = '0;
                    chip_idx_d = '0;
                    div_cnt_d  = '0;
                    chip_cnt_d = '0;
                    r0_d       = '0;
                    r1_d       = '0;
                    rf_d       = '0;
                end else begin
                    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                    if (tick) begin
                        chip_valid_d = 1'b1;
                        chip_idx_d   = chip_cnt_q;
                        epoch_d      = (chip_cnt_q == '0);
                        for (int k = 0; k < N_CH; k++) begin
                            chip_out_d[k] = r0_q[k][LEN-1] ^ r1_q[k][LEN-1] ^ rf_q[k][4];
                        end
                        if (chip_cnt_q == LAST_IDX) begin
                            chip_cnt_d = '0;
                            r0_d       = seed_r0_q;
                            r1_d       = seed_r1_q;
                            rf_d       = seed_rf_q;
                        end else begin
                            chip_cnt_d = chip_cnt_q + 1'b1;
                            for (int k = 0; k < N_CH; k++) begin
                                r0_d[k] = {r0_q[k][LEN-2:0], ^(r0_q[k] & T0_MASK)};
                                r1_d[k] = {r1_q[k][LEN-2:0], ^(r1_q[k] & T1_MASK)
                                          ^ (^(r0_q[k] & CP_MASK) & sigma2(r0_q[k]))};
                                rf_d[k] = {rf_q[k][3:0], rf_q[k][4]};
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            chip_cnt_q   <= '0;
            seed_r0_q    <= '0;
            seed_r1_q    <= '0;
            seed_rf_q    <= '0;
            r0_q         <= '0;
            r1_q         <= '0;
            rf_q         <= '0;
            chip_out_q   <= '0;
            chip_valid_q <= 1'b0;
            epoch_q      <= 1'b0;
            chip_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            chip_cnt_q   <= chip_cnt_d;
            seed_r0_q    <= seed_r0_d;
            seed_r1_q    <= seed_r1_d;
            seed_rf_q    <= seed_rf_d;
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            rf_q         <= rf_d;
            chip_out_q   <= chip_out_d;
            chip_valid_q <= chip_valid_d;
            epoch_q      <= epoch_d;
            chip_idx_q   <= chip_idx_d;
        end
    end

    assign chip_out   = chip_out_q;
    assign chip_valid = chip_valid_q;
    assign epoch      = epoch_q;
    assign chip_idx   = chip_idx_q;
    assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_prn_code_gen_mc.sv
// tb/tb_prn_code_gen_mc.sv - scoreboard bench for prn_code_gen_mc
module tb_prn_code_gen_mc;

    localparam int N_CH = 2;
    localparam int LEN = 55;
    localparam int CODE_LEN = 8;
    localparam int DIV_W = 8;
    localparam int CH_W = 1;
    localparam int IDX_W = 3;
    localparam int SEED_W = 2 * LEN + 5;
    localparam logic [LEN-1:0] T0 = 55'h0FC1;
    localparam logic [LEN-1:0] T1 = 55'h0FC1;
    localparam logic [LEN-1:0] CP = 55'hF101;
    localparam logic [LEN-1:0] SG = 55'h0FC1;

    typedef struct packed {
        logic [N_CH-1:0]  chips;
        logic [IDX_W-1:0] idx;
        logic             ep;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_en = 1'b0;
    logic load_data = 1'b0;
    logic run = 1'b0;
    logic [CH_W-1:0] load_ch = '0;
    logic [DIV_W-1:0] div = '0;
    logic [N_CH-1:0] chip_out;
    logic chip_valid, epoch, busy;
    logic [IDX_W-1:0] chip_idx;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    bit sb_en = 1'b1;
    exp_t sb_q[$];
    int vcyc[$];
    logic [N_CH-1:0] obs_q[$];
    exp_t mon_e;
    logic [LEN-1:0] m_seed_r0[N_CH];
    logic [LEN-1:0] m_seed_r1[N_CH];
    logic [4:0] m_seed_rf[N_CH];

    prn_code_gen_mc #(
        .N_CH(N_CH), .LEN(LEN), .CODE_LEN(CODE_LEN), .DIV_W(DIV_W),
        .T0_MASK(T0), .T1_MASK(T1), .CP_MASK(CP), .SG_MASK(SG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_data(load_data),
        .load_ch(load_ch), .run(run), .div(div), .chip_out(chip_out),
        .chip_valid(chip_valid), .epoch(epoch), .chip_idx(chip_idx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference sigma2 written in its pairwise-AND form
    function automatic logic sig2(input logic [LEN-1:0] a);
        logic s;
        s = 1'b0;
        for (int i = 0; i < LEN; i++)
            for (int j = i + 1; j < LEN; j++)
                s = s ^ (a[i] & a[j]);
        return s;
    endfunction

    task automatic gen_expected(input int n);
        logic [LEN-1:0] r0[N_CH];
        logic [LEN-1:0] r1[N_CH];
        logic [4:0] rf[N_CH];
        logic [LEN-1:0] o0;
        int cnt;
        exp_t e;
        for (int k = 0; k < N_CH; k++) begin
            r0[k] = m_seed_r0[k]; r1[k] = m_seed_r1[k]; rf[k] = m_seed_rf[k];
        end
        cnt = 0;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < N_CH; k++) e.chips[k] = r0[k][LEN-1] ^ r1[k][LEN-1] ^ rf[k][4];
            e.idx = IDX_W'(cnt);
            e.ep = (cnt == 0);
            sb_q.push_back(e);
            if (cnt == CODE_LEN - 1) begin
                cnt = 0;
                for (int k = 0; k < N_CH; k++) begin
                    r0[k] = m_seed_r0[k]; r1[k] = m_seed_r1[k]; rf[k] = m_seed_rf[k];
                end
            end else begin
                cnt++;
                for (int k = 0; k < N_CH; k++) begin
                    o0 = r0[k];
                    r0[k] = {o0[LEN-2:0], ^(o0 & T0)};
                    r1[k] = {r1[k][LEN-2:0], ^(r1[k] & T1) ^ (^(o0 & CP) & sig2(o0 & SG))};
                    rf[k] = {rf[k][3:0], rf[k][4]};
                end
            end
        end
    endtask

    task automatic load_seed(input int ch, input logic [SEED_W-1:0] v);
        load_ch = CH_W'(ch);
        load_en = 1'b1;
        for (int i = SEED_W - 1; i >= 0; i--) begin
            load_data = v[i];
            @(negedge clk);
        end
        load_en = 1'b0;
        load_data = 1'b0;
        m_seed_r0[ch] = v[SEED_W-1 -: LEN];
        m_seed_r1[ch] = v[LEN+4 -: LEN];
        m_seed_rf[ch] = v[4:0];
    endtask

    task automatic run_seq(input int dv, input int n, input bit noise);
        int start, budget, k;
        vcyc.delete();
        obs_q.delete();
        gen_expected(n);
        div = DIV_W'(dv);
        if (noise) begin
            load_en = 1'b1;
            load_data = 1'b1;
        end
        start = cyc;
        run = 1'b1;
        budget = n * (dv + 1) + 20;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
            if (noise) load_data = 1'($urandom_range(0, 1));
        end
        load_en = 1'b0;
        run = 1'b0;
        if (sb_q.size() != 0) begin
            chk("timeout_pending", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clk);
        chk("busy_after_stop", 64'(busy), 64'd0);
        chk("valid_after_stop", 64'(chip_valid), 64'd0);
        chk("chips_after_stop", 64'(chip_out), 64'd0);
        chk("idx_after_stop", 64'(chip_idx), 64'd0);
        chk("n_valid", 64'(vcyc.size()), 64'(n));
        for (int i = 0; i < vcyc.size(); i++)
            chk("valid_cycle", 64'(vcyc[i]), 64'(start + dv + 2 + i * (dv + 1)));
    endtask

    always @(negedge clk) begin
        if (rst_n && epoch && !chip_valid) chk("epoch_without_valid", 64'd1, 64'd0);
        if (rst_n && chip_valid) begin
            vcyc.push_back(cyc);
            obs_q.push_back(chip_out);
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("chip_out", 64'(chip_out), 64'(mon_e.chips));
                    chk("chip_idx", 64'(chip_idx), 64'(mon_e.idx));
                    chk("epoch", 64'(epoch), 64'(mon_e.ep));
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        logic [LEN-1:0] r1a;
        logic [LEN-1:0] r1b;
        logic [LEN-1:0] r0b;
        for (int k = 0; k < N_CH; k++) begin
            m_seed_r0[k] = '0; m_seed_r1[k] = '0; m_seed_rf[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_chip_out", 64'(chip_out), 64'd0);
        chk("rst_valid", 64'(chip_valid), 64'd0);
        chk("rst_epoch", 64'(epoch), 64'd0);
        chk("rst_idx", 64'(chip_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_valid", 64'(chip_valid), 64'd0);

        // flip register only: ch0 chip is 1 only at index 4, period 8
        load_seed(0, SEED_W'(1));
        run_seq(0, 18, 1'b0);
        pat = 8'b0001_0000;
        for (int i = 0; i < obs_q.size(); i++) begin
            chk("flip_ch0", 64'(obs_q[i][0]), 64'(pat[i % 8]));
            chk("flip_ch1", 64'(obs_q[i][1]), 64'd0);
        end

        run_seq(2, 6, 1'b0);

        r1a = {23'($urandom), $urandom};
        r1b = {23'($urandom), $urandom};
        r0b = {23'($urandom), $urandom};
        load_seed(0, {55'h41, r1a, 5'b10110});
        load_seed(1, {r0b, r1b, 5'b01101});
        run_seq(0, 200, 1'b0);
        load_seed(0, {55'hC1, r1a, 5'b10110});
        run_seq(1, 200, 1'b0);

        // load_en asserted alongside run and toggled during RUN must not touch seeds
        run_seq(0, 40, 1'b1);
        run_seq(0, 40, 1'b0);

        sb_en = 1'b0;
        div = '0;
        run = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("midrst_chip_out", 64'(chip_out), 64'd0);
        chk("midrst_valid", 64'(chip_valid), 64'd0);
        chk("midrst_epoch", 64'(epoch), 64'd0);
        chk("midrst_idx", 64'(chip_idx), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_after_busy", 64'(busy), 64'd0);
        chk("midrst_after_valid", 64'(chip_valid), 64'd0);
        for (int k = 0; k < N_CH; k++) begin
            m_seed_r0[k] = '0; m_seed_r1[k] = '0; m_seed_rf[k] = '0;
        end
        sb_en = 1'b1;
        run_seq(0, 10, 1'b0);
        for (int i = 0; i < obs_q.size(); i++)
            chk("cleared_seed_chips", 64'(obs_q[i]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
